// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer constants and byte-merge helper
// No ports. Provides the register map, reset values and a wmask byte merge.
package timer_pkg;

  `include "timer_regs.vh"

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Replace each byte of old_v selected by mask with the matching byte of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_if.sv
// rtl/timer_if.sv - CPU bus bundle for the timer peripheral
// Signals: addr[4:0], ren, wen, wdata, wmask[3:0] (master to slave);
//          rdata, rd_valid, irq (slave to master).
interface timer_if #(
  parameter int W = 32
);
  logic [4:0]   addr;
  logic         ren;
  logic [W-1:0] rdata;
  logic         rd_valid;
  logic         wen;
  logic [W-1:0] wdata;
  logic [3:0]   wmask;
  logic         irq;

  modport master (
    output addr, ren, wen, wdata, wmask,
    input  rdata, rd_valid, irq
  );

  modport slave (
    input  addr, ren, wen, wdata, wmask,
    output rdata, rd_valid, irq
  );
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - prescale counter producing one tick every div+1 enabled cycles
// Ports: clk, rst_n (sync active-low), en (run), clr (restart count),
//        div[PRE_W-1:0] (terminal value), tick (one-cycle strobe).
module timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt_q;
  logic [PRE_W-1:0] pcnt_d;

  always_comb begin
    tick   = en && (pcnt_q == div);
    pcnt_d = pcnt_q + PRE_W'(1);
    // Disabled, a fresh divisor, or a terminal count all restart from zero.
    if (!en || clr || tick) pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/timer_regs.vh
// rtl/timer_regs.vh - timer register map offsets, CTRL bit indices and bus window decode
`ifndef TIMER_REGS_VH
`define TIMER_REGS_VH

localparam logic [4:0] TIMER_CTRL     = 5'h00;
localparam logic [4:0] TIMER_COUNT    = 5'h04;
localparam logic [4:0] TIMER_COMPARE  = 5'h08;
localparam logic [4:0] TIMER_PRESCALE = 5'h0C;
localparam logic [4:0] TIMER_STATUS   = 5'h10;

localparam int CTRL_EN_BIT          = 0;
localparam int CTRL_AUTO_RELOAD_BIT = 1;
localparam int CTRL_IRQ_EN_BIT      = 2;

// addr[15:12] value that selects the timer window on the CPU bus
localparam logic [3:0] TIMER_WINDOW = 4'b0110;

`endif

// File: rtl/timer.sv
// rtl/timer.sv - memory-mapped 32-bit timer with prescaler, compare match and interrupt
// Ports: clk, rst_n (sync active-low), bus (timer_if.slave: addr, ren, wen,
//        wdata, wmask in; rdata, rd_valid, irq out).
module timer
  import timer_pkg::*;
#(
  parameter int W     = 32,
  parameter int PRE_W = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  timer_if.slave bus
);

  logic [2:0]       ctrl_q,     ctrl_d;
  logic [W-1:0]     count_q,    count_d;
  logic [W-1:0]     compare_q,  compare_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             pending_q,  pending_d;
  logic [W-1:0]     rdata_q,    rdata_d;
  logic             rd_valid_q, rd_valid_d;

  logic         wr_ctrl, wr_count, wr_compare, wr_prescale, wr_status;
  logic         tick;
  logic         match;
  logic         w1c;
  logic [W-1:0] rd_val;

  assign wr_ctrl     = bus.wen && (bus.addr == TIMER_CTRL);
  assign wr_count    = bus.wen && (bus.addr == TIMER_COUNT);
  assign wr_compare  = bus.wen && (bus.addr == TIMER_COMPARE);
  assign wr_prescale = bus.wen && (bus.addr == TIMER_PRESCALE);
  assign wr_status   = bus.wen && (bus.addr == TIMER_STATUS);

  timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_q[CTRL_EN_BIT]),
    .clr   (wr_prescale),
    .div   (prescale_q),
    .tick  (tick)
  );

  assign match = tick && (count_q == compare_q);
  assign w1c   = wr_status && bus.wmask[0] && bus.wdata[0];

  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    pending_d  = pending_q;

    if (wr_ctrl && bus.wmask[0]) ctrl_d = bus.wdata[2:0];

    if (tick) begin
      if (match && ctrl_q[CTRL_AUTO_RELOAD_BIT]) count_d = '0;
      else                                       count_d = count_q + W'(1);
    end
    // A CPU write lands after the tick update so it wins the collision.
    if (wr_count) count_d = byte_merge(count_q, bus.wdata, bus.wmask);

    if (wr_compare) compare_d = byte_merge(compare_q, bus.wdata, bus.wmask);

    if (wr_prescale)
      prescale_d = PRE_W'(byte_merge(W'(prescale_q), bus.wdata, bus.wmask));

    // Set is applied last so a match beats a same-cycle clear.
    if (w1c)   pending_d = 1'b0;
    if (match) pending_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      TIMER_CTRL:     rd_val = W'(ctrl_q);
      TIMER_COUNT:    rd_val = count_q;
      TIMER_COMPARE:  rd_val = compare_q;
      TIMER_PRESCALE: rd_val = W'(prescale_q);
      TIMER_STATUS:   rd_val = W'(pending_q);
      default:        rd_val = '0;
    endcase
    // Reads sample the pre-write register state; rdata holds between reads.
    rdata_d    = bus.ren ? rd_val : rdata_q;
    rd_valid_d = bus.ren;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
      prescale_q <= '0;
      pending_q  <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      pending_q  <= pending_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.irq      = pending_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral on the CPU bus, decoded at addr[15:12] == 4'b0110 alongside led and uart.
- Consumes the CPU bus strobes and produces registered read data, a read-valid pulse and a level interrupt (irq) for the CPU.
- Provides a free-running, prescaled counter with a compare match, optional auto-reload and a sticky pending flag.

Parameters:
- W, 32, bus data width; must be 32.
- PRE_W, 16, prescaler register and counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- addr  in  5  byte offset within timer window (addr[4:0]); only word offsets are decoded
- ren  in  1  read strobe, one cycle
- rdata  out  W  read data
- rd_valid  out  1  one-cycle pulse marking rdata valid
- wen  in  1  write strobe, one cycle
- wdata  in  W  write data
- wmask  in  4  byte enables, bit i for wdata[8i+7:8i]
- irq  out  1  interrupt, level

Behaviour:
- Registers (offset, reset value):
  - 0x00 CTRL (0): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 COUNT (0): read/write.
  - 0x08 COMPARE (0xFFFFFFFF).
  - 0x0C PRESCALE (0): low PRE_W bits used.
  - 0x10 STATUS (0): bit0 PENDING, write-1-to-clear.
  - Unmapped offsets read 0; writes to them are ignored.
- Reset: when rst_n == 0 at a clk edge, all registers and the prescaler counter take their reset values; rdata = 0, rd_valid = 0, irq = 0. Reset mid-count discards all state with no residual tick.
- Read:
  - A read with ren=1 in cycle N gives rd_valid=1 and rdata=register value in cycle N+1; rd_valid=0 otherwise.
  - rdata holds its last value until the next read.
  - Back-to-back reads give back-to-back valid pulses.
- Write:
  - wen=1 updates the selected register at the clk edge, byte-wise per wmask.
  - A write to STATUS clears PENDING if the byte-0 mask bit is set and wdata[0]=1.
  - ren and wen in the same cycle: the write is performed and the read returns the pre-write value.
- Prescaler:
  - Counter pcnt runs while EN=1.
  - When pcnt == PRESCALE, a tick is generated and pcnt <= 0; otherwise pcnt <= pcnt+1.
  - PRESCALE = 0 gives a tick every cycle.
  - EN=0 holds pcnt at 0, and no tick is generated.
  - A write to PRESCALE also clears pcnt.
- Counter, on each tick:
  - If COUNT == COMPARE: PENDING <= 1, and COUNT <= 0 if AUTO_RELOAD, else COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - Arithmetic is modulo 2^32 (0xFFFFFFFF wraps to 0).
- Simultaneous events:
  - A CPU write to COUNT in the same cycle as a tick: the write wins and the tick increment is lost.
  - A PENDING set and a W1C clear in the same cycle: set wins and PENDING stays 1.
- irq = PENDING & IRQ_EN, registered and combinational from registers only. irq drops the cycle after PENDING is cleared or IRQ_EN is cleared.
- rd_valid timing is identical for every offset; the block never stalls.

Decomposition:
- Shared include timer_regs.vh:
  - localparams for register offsets (TIMER_CTRL=5'h00, TIMER_COUNT=5'h04, TIMER_COMPARE=5'h08, TIMER_PRESCALE=5'h0C, TIMER_STATUS=5'h10);
  - CTRL bit indices;
  - the window decode value 4'b0110.
- Sub-module timer_prescaler:
  - inputs clk, rst_n, en, clr, div[PRE_W-1:0];
  - output tick;
  - it owns pcnt.
- The top-level timer holds the register file, bus read/write logic, counter and irq.

Test Plan:
- Reset: with rst_n=0 for 2 cycles, then read every offset. Expect CTRL=0, COUNT=0, COMPARE=0xFFFFFFFF, PRESCALE=0, STATUS=0, irq=0, and rd_valid exactly 1 cycle after each ren.
- Prescale: write PRESCALE=3, CTRL=1, then wait 40 cycles. Expect COUNT=10 (±1 depending on read edge). With CTRL=0, COUNT is frozen across 20 further cycles.
- Compare with auto-reload:
  - Write COMPARE=5, PRESCALE=0, CTRL=7.
  - Expect PENDING=1 and COUNT to go 5→0 on the same tick, and irq=1 on the next cycle.
  - Write STATUS=1; expect irq=0 one cycle later.
- Wrap:
  - Write COUNT=0xFFFFFFFE, COMPARE=0x10, CTRL=1.
  - Expect COUNT to go 0xFFFFFFFF → 0 → 1 with no PENDING.
- Byte mask: write COMPARE=0xAABBCCDD with wmask=4'b0101 over 0xFFFFFFFF. Expect a read of 0xFFBBFFDD.
- Collisions:
  - Issue a W1C to STATUS on the same edge as a compare match; expect PENDING=1.
  - Write COUNT=0x100 on a tick edge; expect a readback of 0x100.
  - Assert rst_n=0 for one cycle mid-count; expect all registers to return to reset values.
